// File: rtl/rx_latency_probe.sv
// rx_latency_probe: zero-latency RX AXI-stream monitor measuring per-packet latency (vita_time - timestamp).
// Optional macro RX_LAT_PROBE_STAMP_EN replaces BODY-beat tdata with the current packet's latency.
module rx_latency_probe #(
    parameter logic [7:0] SR_LAT_CTRL = 8'd200,
    parameter logic [7:0] RB_LAT_BASE = 8'd40,
    parameter int         LAT_W       = 32
) (
    input  logic         radio_clk,
    input  logic         radio_rst,
    input  logic [63:0]  vita_time,
    input  logic         set_stb,
    input  logic [7:0]   set_addr,
    input  logic [31:0]  set_data,
    input  logic [7:0]   rb_addr,
    output logic         rb_stb,
    output logic [63:0]  rb_data,
    input  logic [31:0]  i_tdata,
    input  logic [127:0] i_tuser,
    input  logic         i_tlast,
    input  logic         i_tvalid,
    output logic         i_tready,
    output logic [31:0]  o_tdata,
    output logic [127:0] o_tuser,
    output logic         o_tlast,
    output logic         o_tvalid,
    input  logic         o_tready
);
    typedef enum logic {ST_SOP, ST_BODY} state_t;

    state_t            state_q, state_d;
    logic              enable_q, enable_d;
    logic [LAT_W-1:0]  last_q, last_d, min_q, min_d, max_q, max_d;
    logic [31:0]       pkt_cnt_q, pkt_cnt_d, early_cnt_q, early_cnt_d;
    logic [47:0]       sum_q, sum_d;
    logic              rb_stb_q, rb_stb_d;
    logic [63:0]       rb_data_q, rb_data_d;

    logic              beat, sop_beat, ctrl_wr, clear, measure;
    logic [63:0]       diff;
    logic [LAT_W-1:0]  lat;
    logic [7:0]        rb_off;

    // Any difference that does not fit in LAT_W bits pins to all-ones.
    function automatic logic [LAT_W-1:0] sat_lat(input logic [63:0] d);
        if (d[63:LAT_W] != '0) return '1;
        return d[LAT_W-1:0];
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] c);
        return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
    endfunction

    assign i_tready = o_tready;
    assign o_tvalid = i_tvalid;
    assign o_tlast  = i_tlast;
    assign o_tuser  = i_tuser;

    assign beat     = i_tvalid & o_tready;
    assign sop_beat = beat & (state_q == ST_SOP);
    assign ctrl_wr  = set_stb & (set_addr == SR_LAT_CTRL);
    assign clear    = ctrl_wr & set_data[1];
    assign diff     = vita_time - i_tuser[63:0];
    assign lat      = sat_lat(diff);
    // A coincident clear suppresses the measurement entirely.
    assign measure  = sop_beat & enable_q & i_tuser[125] & ~clear;

    always_comb begin
        state_d     = state_q;
        enable_d    = enable_q;
        last_d      = last_q;
        min_d       = min_q;
        max_d       = max_q;
        pkt_cnt_d   = pkt_cnt_q;
        early_cnt_d = early_cnt_q;
        sum_d       = sum_q;

        if (beat) begin
            if (i_tlast)                  state_d = ST_SOP;
            else if (state_q == ST_SOP)   state_d = ST_BODY;
        end

        if (ctrl_wr) enable_d = set_data[0];

        if (clear) begin
            last_d      = '0;
            min_d       = '1;
            max_d       = '0;
            pkt_cnt_d   = '0;
            early_cnt_d = '0;
            sum_d       = '0;
        end else if (measure) begin
            if (diff[63]) begin
                early_cnt_d = sat_inc(early_cnt_q);
            end else begin
                last_d    = lat;
                min_d     = (lat < min_q) ? lat : min_q;
                max_d     = (lat > max_q) ? lat : max_q;
                pkt_cnt_d = sat_inc(pkt_cnt_q);
                sum_d     = sum_q + 48'(lat);
            end
        end
    end

    always_comb begin
        rb_off    = rb_addr - RB_LAT_BASE;
        rb_stb_d  = 1'b1;
        rb_data_d = '0;
        case (rb_off)
            8'd0:    rb_data_d = 64'(last_q);
            8'd1:    rb_data_d = 64'(min_q);
            8'd2:    rb_data_d = 64'(max_q);
            8'd3:    rb_data_d = {early_cnt_q, pkt_cnt_q};
            8'd4:    rb_data_d = {16'd0, sum_q};
            8'd5:    rb_data_d = {63'd0, enable_q};
            default: rb_stb_d  = 1'b0;
        endcase
    end

    always_ff @(posedge radio_clk or posedge radio_rst) begin
        if (radio_rst) begin
            state_q     <= ST_SOP;
            enable_q    <= 1'b0;
            last_q      <= '0;
            min_q       <= '1;
            max_q       <= '0;
            pkt_cnt_q   <= '0;
            early_cnt_q <= '0;
            sum_q       <= '0;
            rb_stb_q    <= 1'b0;
            rb_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            enable_q    <= enable_d;
            last_q      <= last_d;
            min_q       <= min_d;
            max_q       <= max_d;
            pkt_cnt_q   <= pkt_cnt_d;
            early_cnt_q <= early_cnt_d;
            sum_q       <= sum_d;
            rb_stb_q    <= rb_stb_d;
            rb_data_q   <= rb_data_d;
        end
    end

    assign rb_stb  = rb_stb_q;
    assign rb_data = rb_data_q;

`ifdef RX_LAT_PROBE_STAMP_EN
    // Stamp latches at SOP; unmeasured or early packets stamp zero.
    logic [LAT_W-1:0] stamp_q, stamp_d;

    always_comb begin
        stamp_d = stamp_q;
        if (sop_beat) stamp_d = (measure && !diff[63]) ? lat : '0;
    end

    always_ff @(posedge radio_clk or posedge radio_rst) begin
        if (radio_rst) stamp_q <= '0;
        else           stamp_q <= stamp_d;
    end

    assign o_tdata = (state_q == ST_BODY) ? 32'(stamp_q) : i_tdata;
`else
    assign o_tdata = i_tdata;
`endif

endmodule

// File: tb/tb_rx_latency_probe.sv
// Self-checking bench for rx_latency_probe: packet-list reference model plus directed literal checks.
module tb_rx_latency_probe;
    localparam logic [7:0] CTRL = 8'd200;
    localparam logic [7:0] BASE = 8'd40;

    logic         radio_clk = 1'b0;
    logic         radio_rst = 1'b0;
    logic [63:0]  vita_time = '0;
    logic         set_stb = 1'b0;
    logic [7:0]   set_addr = '0;
    logic [31:0]  set_data = '0;
    logic [7:0]   rb_addr = 8'd0;
    logic         rb_stb;
    logic [63:0]  rb_data;
    logic [31:0]  i_tdata = '0;
    logic [127:0] i_tuser = '0;
    logic         i_tlast = 1'b0;
    logic         i_tvalid = 1'b0;
    logic         i_tready;
    logic [31:0]  o_tdata;
    logic [127:0] o_tuser;
    logic         o_tlast;
    logic         o_tvalid;
    logic         o_tready = 1'b1;

    int checks = 0;
    int failures = 0;
    logic rnd_rdy = 1'b0;

    // Reference model: the list of latencies measured since the last clear/reset.
    logic [31:0] m_lats[$];
    logic [31:0] m_early = '0;
    logic        m_en = 1'b0;
    int          m_idx = 0;
    logic [31:0] m_stamp = '0;
    logic [63:0] exp_rb = '0;
    logic        exp_rbstb = 1'b0;

    rx_latency_probe dut (
        .radio_clk(radio_clk), .radio_rst(radio_rst), .vita_time(vita_time),
        .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
        .rb_addr(rb_addr), .rb_stb(rb_stb), .rb_data(rb_data),
        .i_tdata(i_tdata), .i_tuser(i_tuser), .i_tlast(i_tlast), .i_tvalid(i_tvalid),
        .i_tready(i_tready), .o_tdata(o_tdata), .o_tuser(o_tuser), .o_tlast(o_tlast),
        .o_tvalid(o_tvalid), .o_tready(o_tready)
    );

    always #5 radio_clk = ~radio_clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] rb_val(input logic [7:0] a);
        logic [7:0]  off;
        logic [31:0] mn, mx, lst, cnt;
        logic [47:0] s;
        off = a - BASE;
        mn = 32'hFFFF_FFFF; mx = '0; lst = '0; s = '0;
        foreach (m_lats[i]) begin
            if (m_lats[i] < mn) mn = m_lats[i];
            if (m_lats[i] > mx) mx = m_lats[i];
            s = s + 48'(m_lats[i]);
        end
        if (m_lats.size() > 0) lst = m_lats[m_lats.size()-1];
        cnt = (m_lats.size() > 32'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(m_lats.size());
        case (off)
            8'd0: return {32'd0, lst};
            8'd1: return {32'd0, mn};
            8'd2: return {32'd0, mx};
            8'd3: return {m_early, cnt};
            8'd4: return {16'd0, s};
            8'd5: return {63'd0, m_en};
            default: return 64'd0;
        endcase
    endfunction

    task automatic model_step();
        logic        clr;
        logic [63:0] diff;
        logic [31:0] lat;
        logic [7:0]  off;
        if (radio_rst) begin
            m_lats.delete(); m_early = '0; m_en = 1'b0; m_idx = 0; m_stamp = '0;
            exp_rb = '0; exp_rbstb = 1'b0;
            return;
        end
        off = rb_addr - BASE;
        exp_rb = rb_val(rb_addr);
        exp_rbstb = (off < 8'd6);
        clr = set_stb && (set_addr == CTRL) && set_data[1];
        if (i_tvalid && o_tready) begin
            if (m_idx == 0) begin
                m_stamp = '0;
                if (m_en && i_tuser[125] && !clr) begin
                    diff = vita_time - i_tuser[63:0];
                    if (diff[63]) begin
                        if (m_early != 32'hFFFF_FFFF) m_early = m_early + 1;
                    end else begin
                        lat = (diff > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : diff[31:0];
                        m_lats.push_back(lat);
                        m_stamp = lat;
                    end
                end
            end
            m_idx = i_tlast ? 0 : m_idx + 1;
        end
        if (clr) begin m_lats.delete(); m_early = '0; end
        if (set_stb && (set_addr == CTRL)) m_en = set_data[0];
    endtask

    initial forever begin
        @(posedge radio_clk or posedge radio_rst);
        model_step();
    end

    // Continuous compare of the pass-through path and readback against the model.
    initial forever begin
        logic [31:0] exp_td;
        @(negedge radio_clk);
        exp_td = i_tdata;
`ifdef RX_LAT_PROBE_STAMP_EN
        if (m_idx != 0) exp_td = m_stamp;
`endif
        check("i_tready", i_tready, o_tready);
        check("o_tvalid", o_tvalid, i_tvalid);
        check("o_tlast", o_tlast, i_tlast);
        check("o_tuser", o_tuser, i_tuser);
        check("o_tdata", o_tdata, exp_td);
        check("rb_stb", rb_stb, exp_rbstb);
        check("rb_data", rb_data, exp_rb);
    end

    initial forever begin
        @(posedge radio_clk);
        #1;
        if (rnd_rdy) o_tready = ($urandom % 4) != 0;
    end

    task automatic wr_ctrl(input logic [7:0] a, input logic [31:0] d);
        set_stb = 1'b1; set_addr = a; set_data = d;
        @(posedge radio_clk); #1;
        set_stb = 1'b0;
    endtask

    task automatic rd_expect(input string name, input logic [7:0] off, input logic [63:0] exp);
        rb_addr = BASE + off;
        @(posedge radio_clk);
        @(negedge radio_clk);
        check(name, rb_data, exp);
        @(posedge radio_clk); #1;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [127:0] u, input logic l,
                             input logic [63:0] vt);
        int   n;
        logic acc;
        n = 0; acc = 1'b0;
        i_tdata = d; i_tuser = u; i_tlast = l; vita_time = vt; i_tvalid = 1'b1;
        while (!acc) begin
            @(posedge radio_clk);
            acc = o_tready;
            #1;
            n++;
            if (!acc && n >= 200) begin
                checks++; failures++;
                $display("FAIL beat_timeout: no handshake within 200 cycles");
                acc = 1'b1;
            end
        end
    endtask

    task automatic send_pkt(input int nb, input logic [63:0] ts, input logic [63:0] vt, input logic ht);
        logic [63:0] hdr;
        for (int b = 0; b < nb; b++) begin
            hdr = {$urandom, $urandom};
            hdr[61] = ht;
            send_beat($urandom, {hdr, ts}, (b == nb - 1), vt + 64'(b * 3));
        end
        i_tvalid = 1'b0;
    endtask

    initial begin
        logic [63:0] hdr, ts, dl;
        int k;
        #1 radio_rst = 1'b1;
        repeat (3) @(posedge radio_clk);
        #1 radio_rst = 1'b0;

        rd_expect("rst_last", 0, 64'd0);
        rd_expect("rst_min", 1, 64'h0000_0000_FFFF_FFFF);
        rd_expect("rst_max", 2, 64'd0);
        rd_expect("rst_cnts", 3, 64'd0);
        rd_expect("rst_sum", 4, 64'd0);
        rd_expect("rst_en", 5, 64'd0);
        rd_expect("oob_hi", 6, 64'd0);
        rb_addr = BASE - 8'd1;
        @(posedge radio_clk); @(negedge radio_clk);
        check("oob_lo_stb", rb_stb, 1'b0);
        @(posedge radio_clk); #1;

        wr_ctrl(CTRL, 32'd1);
        send_pkt(4, 64'd100, 64'd130, 1'b1);
        rd_expect("p1_last", 0, 64'd30);
        rd_expect("p1_min", 1, 64'd30);
        rd_expect("p1_max", 2, 64'd30);
        rd_expect("p1_cnts", 3, 64'd1);
        rd_expect("p1_sum", 4, 64'd30);

        wr_ctrl(CTRL, 32'd3);
        send_pkt(3, 64'd1000, 64'd1030, 1'b1);
        send_pkt(2, 64'd2000, 64'd2010, 1'b1);
        send_pkt(5, 64'd3000, 64'd3050, 1'b1);
        send_pkt(2, 64'd4000, 64'd4099, 1'b0);
        rd_expect("p3_min", 1, 64'd10);
        rd_expect("p3_max", 2, 64'd50);
        rd_expect("p3_last", 0, 64'd50);
        rd_expect("p3_cnts", 3, 64'd3);
        rd_expect("p3_sum", 4, 64'd90);

        send_pkt(2, 64'd5005, 64'd5000, 1'b1);
        rd_expect("early_cnts", 3, 64'h1_0000_0003);
        send_pkt(2, 64'd0, 64'h100_0000_0000, 1'b1);
        rd_expect("sat_last", 0, 64'hFFFF_FFFF);
        rd_expect("sat_sum", 4, 64'h1_0000_0059);

        hdr = 64'h2000_0000_0000_0000;
        send_beat(32'h11, {hdr, 64'd200}, 1'b0, 64'd207);
        o_tready = 1'b0;
        i_tdata = 32'h22; i_tlast = 1'b0; i_tvalid = 1'b1;
        repeat (3) begin
            @(negedge radio_clk);
            check("stall_tready", i_tready, 1'b0);
            @(posedge radio_clk); #1;
        end
        o_tready = 1'b1;
        send_beat(32'h22, {hdr, 64'd200}, 1'b0, 64'd500);
        send_beat(32'h33, {hdr, 64'd200}, 1'b0, 64'd501);
        send_beat(32'h44, {hdr, 64'd200}, 1'b1, 64'd502);
        i_tvalid = 1'b0;
        send_pkt(1, 64'd300, 64'd301, 1'b1);
        send_pkt(1, 64'd400, 64'd402, 1'b1);
        rd_expect("stall_cnts", 3, 64'h1_0000_0007);
        rd_expect("stall_min", 1, 64'd1);
        rd_expect("stall_last", 0, 64'd2);

        set_stb = 1'b1; set_addr = CTRL; set_data = 32'd3;
        send_beat(32'h55, {hdr, 64'd600}, 1'b1, 64'd640);
        set_stb = 1'b0; i_tvalid = 1'b0;
        rd_expect("clr_last", 0, 64'd0);
        rd_expect("clr_min", 1, 64'h0000_0000_FFFF_FFFF);
        rd_expect("clr_cnts", 3, 64'd0);
        rd_expect("clr_sum", 4, 64'd0);
        rd_expect("clr_en", 5, 64'd1);

        send_beat(32'h66, {hdr, 64'd10}, 1'b0, 64'd20);
        send_beat(32'h77, {hdr, 64'd10}, 1'b0, 64'd21);
        i_tvalid = 1'b0;
        radio_rst = 1'b1;
        @(posedge radio_clk); #1;
        radio_rst = 1'b0;
        rd_expect("mrst_en", 5, 64'd0);
        wr_ctrl(CTRL, 32'd1);
        send_pkt(3, 64'd50, 64'd75, 1'b1);
        rd_expect("mrst_cnts", 3, 64'd1);
        rd_expect("mrst_last", 0, 64'd25);

        rnd_rdy = 1'b1;
        repeat (150) begin
            k = $urandom % 16;
            rb_addr = BASE - 8'd1 + 8'($urandom % 8);
            if (k == 0) begin
                wr_ctrl(CTRL, {30'd0, ($urandom % 8) == 0, ($urandom % 4) != 0});
            end else if (k == 1) begin
                wr_ctrl(CTRL + 8'd1, 32'd2);
            end else begin
                ts = {$urandom, $urandom};
                case ($urandom % 8)
                    5:       dl = -64'(1 + $urandom % 50);
                    6:       dl = 64'h1_0000_0000 + 64'($urandom);
                    7:       dl = 64'h1_0000_0000 - 64'($urandom % 2);
                    default: dl = 64'($urandom % 2000);
                endcase
                send_pkt(1 + $urandom % 5, ts, ts + dl, ($urandom % 8) != 0);
            end
        end
        rnd_rdy = 1'b0;
        @(posedge radio_clk); #1;
        o_tready = 1'b1;
        for (int i = 0; i < 6; i++) rd_expect("final_rb", 8'(i), rb_val(BASE + 8'(i)));

        repeat (3) @(posedge radio_clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
